// File: rtl/ccip_if_pkg.sv
// Minimal CCI-P channel type definitions used by the interrupt controller.
// Only the header fields the controller reads or drives are broken out; the
// rest is kept as reserved padding so the structs keep a CCI-P-like shape.
package ccip_if_pkg;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [13:0]  rsvd1;
    t_ccip_c1_rsp resp_type;
    logic [3:0]   rsvd0;
    logic [1:0]   id;
  } t_ccip_c1_RspIntrHdr;

  typedef struct packed {
    t_ccip_c1_RspIntrHdr hdr;
    logic                rspValid;
  } t_if_ccip_c1_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
    t_if_ccip_c1_Rx c1;
  } t_if_ccip_Rx;

  typedef struct packed {
    logic [73:0] hdr;
    logic        valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    logic [5:0]   rsvd1;
    t_ccip_c1_req req_type;
    logic [61:0]  rsvd0;
    logic [1:0]   id;
  } t_ccip_c1_ReqIntrHdr;

  typedef struct packed {
    t_ccip_c1_ReqIntrHdr hdr;
    logic [511:0]        data;
    logic                valid;
  } t_if_ccip_c1_Tx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    t_if_ccip_c0_Tx c0;
    t_if_ccip_c1_Tx c1;
    t_if_ccip_c2_Tx c2;
  } t_if_ccip_Tx;

endpackage

// File: rtl/ccip_intr_ctrl.sv
// Multi-vector CCI-P user-interrupt controller AFU.
// Software raises vectors through MMIO (TRIGGER), vectors are held by MASK and
// by their own in-flight request, and a round-robin arbiter issues at most one
// eREQ_INTR per cycle on c1. Each vector retires on its matching eRSP_INTR.
// Ports:
//   Clk_400        core clock
//   SoftReset      asynchronous active-high reset
//   cp2af_sRxPort  c0 MMIO requests, c1 interrupt responses, c1TxAlmFull
//   af2cp_sTxPort  c1 interrupt requests, c2 MMIO read responses, c0 idle
module ccip_intr_ctrl
  import ccip_if_pkg::*;
#(
  parameter int unsigned NUM_VECTORS = 4,
  parameter logic [63:0] AFU_ID_H    = 64'h850A_DCC2_6CEB_4B23,
  parameter logic [63:0] AFU_ID_L    = 64'h9722_D433_75B6_1C67
) (
  input  logic        Clk_400,
  input  logic        SoftReset,
  input  t_if_ccip_Rx cp2af_sRxPort,
  output t_if_ccip_Tx af2cp_sTxPort
);

  // Vector state is kept 4 bits wide; bits at or above NUM_VECTORS never set.
  localparam logic [3:0]  VecMask     = 4'((1 << NUM_VECTORS) - 1);
  localparam logic [63:0] Dfh         = {4'h1, 19'h0, 1'b1, 40'h0};
  localparam logic [15:0] AddrDfh     = 16'h0000;
  localparam logic [15:0] AddrIdL     = 16'h0002;
  localparam logic [15:0] AddrIdH     = 16'h0004;
  localparam logic [15:0] AddrScratch = 16'h0020;
  localparam logic [15:0] AddrTrigger = 16'h0028;
  localparam logic [15:0] AddrMask    = 16'h0030;
  localparam logic [15:0] AddrStatus  = 16'h0032;
  localparam logic [15:0] AddrSentCnt = 16'h0038;
  localparam logic [15:0] AddrAckCnt  = 16'h003A;

  logic [3:0]  pending_q, pending_d, mask_q, mask_d, inflight_q, inflight_d;
  logic [63:0] scratch_q, scratch_d;
  logic [31:0] sent_cnt_q, sent_cnt_d, ack_cnt_q, ack_cnt_d;
  logic [1:0]  rr_q, rr_d;
  t_if_ccip_Tx tx_q, tx_d;

  t_ccip_c0_ReqMmioHdr mmio_hdr;
  logic [63:0]         wr_data;
  logic [3:0]          wr_vec;
  logic [63:0]         rd_data;

  assign mmio_hdr = cp2af_sRxPort.c0.hdr;
  assign wr_data  = cp2af_sRxPort.c0.data[63:0];
  assign wr_vec   = wr_data[3:0] & VecMask;

  logic unused_rx;
  assign unused_rx = ^{cp2af_sRxPort.c0TxAlmFull, cp2af_sRxPort.c0.rspValid,
                       cp2af_sRxPort.c0.data[511:64], mmio_hdr.length, mmio_hdr.rsvd,
                       cp2af_sRxPort.c1.hdr.rsvd1, cp2af_sRxPort.c1.hdr.rsvd0};

  // Round-robin search starting at rr_q; one wrap-around subtraction suffices
  // because both rr_q and the offset are below NUM_VECTORS.
  logic [3:0] elig;
  logic       grant_vld;
  logic [1:0] grant_idx;
  logic [2:0] cand;
  logic [2:0] rr_nxt;
  logic       issue;

  always_comb begin
    elig      = pending_q & ~mask_q & ~inflight_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = 0; i < int'(NUM_VECTORS); i++) begin
      cand = {1'b0, rr_q} + 3'(i);
      if (cand >= 3'(NUM_VECTORS)) cand = cand - 3'(NUM_VECTORS);
      if (!grant_vld && elig[cand[1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[1:0];
      end
    end
    rr_nxt = {1'b0, grant_idx} + 3'd1;
    if (rr_nxt == 3'(NUM_VECTORS)) rr_nxt = '0;
  end

  assign issue = grant_vld & ~cp2af_sRxPort.c1TxAlmFull;

  // Responses only count against a vector that actually has a request out.
  logic rsp_hit;
  assign rsp_hit = cp2af_sRxPort.c1.rspValid &&
                   (cp2af_sRxPort.c1.hdr.resp_type == eRSP_INTR) &&
                   inflight_q[cp2af_sRxPort.c1.hdr.id];

  // Later assignments win: a trigger landing on the issue cycle re-arms.
  always_comb begin
    pending_d  = pending_q;
    mask_d     = mask_q;
    inflight_d = inflight_q;
    scratch_d  = scratch_q;
    sent_cnt_d = sent_cnt_q;
    ack_cnt_d  = ack_cnt_q;
    rr_d       = rr_q;
    if (issue) begin
      pending_d  = pending_d & ~(4'b0001 << grant_idx);
      inflight_d = inflight_d | (4'b0001 << grant_idx);
      sent_cnt_d = sent_cnt_q + 32'd1;
      rr_d       = rr_nxt[1:0];
    end
    if (rsp_hit) begin
      inflight_d = inflight_d & ~(4'b0001 << cp2af_sRxPort.c1.hdr.id);
      ack_cnt_d  = ack_cnt_q + 32'd1;
    end
    if (cp2af_sRxPort.c0.mmioWrValid) begin
      case (mmio_hdr.address)
        AddrScratch: scratch_d = wr_data;
        AddrTrigger: pending_d = pending_d | wr_vec;
        AddrMask:    mask_d    = wr_vec;
        AddrStatus:  pending_d = pending_d & ~wr_vec;
        default:     ;
      endcase
    end
  end

  always_comb begin
    case (mmio_hdr.address)
      AddrDfh:     rd_data = Dfh;
      AddrIdL:     rd_data = AFU_ID_L;
      AddrIdH:     rd_data = AFU_ID_H;
      AddrScratch: rd_data = scratch_q;
      AddrTrigger: rd_data = {60'h0, pending_q};
      AddrMask:    rd_data = {60'h0, mask_q};
      AddrStatus:  rd_data = {52'h0, inflight_q, 4'h0, pending_q};
      AddrSentCnt: rd_data = {32'h0, sent_cnt_q};
      AddrAckCnt:  rd_data = {32'h0, ack_cnt_q};
      default:     rd_data = '0;
    endcase
  end

  // Whole Tx port is registered; every non-issue / non-read cycle is all-zero.
  always_comb begin
    tx_d = '0;
    if (issue) begin
      tx_d.c1.valid        = 1'b1;
      tx_d.c1.hdr.req_type = eREQ_INTR;
      tx_d.c1.hdr.id       = grant_idx;
    end
    if (cp2af_sRxPort.c0.mmioRdValid) begin
      tx_d.c2.mmioRdValid = 1'b1;
      tx_d.c2.hdr.tid     = mmio_hdr.tid;
      tx_d.c2.data        = rd_data;
    end
  end

  always_ff @(posedge Clk_400 or posedge SoftReset) begin
    if (SoftReset) begin
      pending_q  <= '0;
      mask_q     <= '0;
      inflight_q <= '0;
      scratch_q  <= '0;
      sent_cnt_q <= '0;
      ack_cnt_q  <= '0;
      rr_q       <= '0;
      tx_q       <= '0;
    end else begin
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      inflight_q <= inflight_d;
      scratch_q  <= scratch_d;
      sent_cnt_q <= sent_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      rr_q       <= rr_d;
      tx_q       <= tx_d;
    end
  end

  assign af2cp_sTxPort = tx_q;

endmodule
